// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station.
//  - alu_op_t / nzcv_t       : ALU opcode and condition flags
//  - `GPR_SIZE/`ROB_IDX_SIZE : register and ROB-tag widths (defaulted here if not already defined)
//  - rs_entry_t              : one reservation-station slot
//  - rs_issue_t              : fields handed to the ALU on issue
//  - rs_wakeup()             : applies an FU completion broadcast to one slot
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 5
`endif

package alu_rs_pkg;

  typedef enum logic [3:0] {
    ALU_PLUS, ALU_MINUS, ALU_AND, ALU_ORR, ALU_EOR, ALU_LSL, ALU_LSR, ALU_MOV
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef logic [`GPR_SIZE-1:0]     gpr_t;
  typedef logic [`ROB_IDX_SIZE-1:0] rob_idx_t;

  typedef struct packed {
    logic     valid;
    alu_op_t  op;
    gpr_t     a_val;
    logic     a_ready;
    rob_idx_t a_tag;
    gpr_t     b_val;
    logic     b_ready;
    rob_idx_t b_tag;
    nzcv_t    nzcv;
    logic     nzcv_ready;
    rob_idx_t nzcv_tag;
    logic     set_nzcv;
    rob_idx_t dst;
  } rs_entry_t;

  typedef struct packed {
    alu_op_t  op;
    gpr_t     a_val;
    gpr_t     b_val;
    rob_idx_t dst;
    logic     set_nzcv;
    nzcv_t    nzcv;
  } rs_issue_t;

  // Capture any operand still waiting on the broadcasting tag. Flags only
  // wake when the producer actually wrote them.
  function automatic rs_entry_t rs_wakeup(rs_entry_t e, logic done, rob_idx_t tag,
                                          gpr_t val, logic set_nzcv, nzcv_t nzcv);
    rs_entry_t r;
    r = e;
    if (e.valid && done) begin
      if (!e.a_ready && e.a_tag == tag) begin
        r.a_val   = val;
        r.a_ready = 1'b1;
      end
      if (!e.b_ready && e.b_tag == tag) begin
        r.b_val   = val;
        r.b_ready = 1'b1;
      end
      if (!e.nzcv_ready && set_nzcv && e.nzcv_tag == tag) begin
        r.nzcv       = nzcv;
        r.nzcv_ready = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for the reservation station.
//  older_q[r][c] = 1 means slot r was dispatched before slot c.
//  Ports: in_clk/in_rst (async high), alloc_oh (one-hot slot being written
//  this edge), valid (current slot valid vector), ready (issue candidates),
//  grant (one-hot oldest candidate, combinational).
module rs_age_matrix #(
  parameter int RS_SIZE = 8
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic [RS_SIZE-1:0] alloc_oh,
  input  logic [RS_SIZE-1:0] valid,
  input  logic [RS_SIZE-1:0] ready,
  output logic [RS_SIZE-1:0] grant
);

  logic [RS_SIZE-1:0][RS_SIZE-1:0] older_q;
  logic [RS_SIZE-1:0]              blk;

  // New slot is younger than everything live: nothing is younger than it
  // (row cleared) and every live slot is older than it (column set).
  // Stale bits of dead slots are harmless: ready excludes them and the
  // row/column is rewritten on reallocation.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      older_q <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (alloc_oh[i]) begin
          for (int j = 0; j < RS_SIZE; j++) begin
            older_q[i][j] <= 1'b0;
            older_q[j][i] <= valid[j] && (j != i);
          end
        end
      end
    end
  end

  // A candidate is blocked if any older slot is also a candidate.
  always_comb begin
    for (int c = 0; c < RS_SIZE; c++) begin
      blk[c] = 1'b0;
      for (int r = 0; r < RS_SIZE; r++)
        blk[c] = blk[c] | (older_q[r][c] & ready[r]);
    end
  end

  assign grant = ready & ~blk;

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ALU ops, snoops the FU completion
// broadcast for pending operands/flags, and issues the oldest fully-ready op
// with a registered one-cycle start pulse.
//  Ports:
//   in_clk, in_rst (async, active-high), in_flush (drop all entries)
//   in_dispatch_* / out_dispatch_ready : dispatch interface
//   in_fu_done, in_fu_dst_rob_index, in_fu_value, in_fu_set_nzcv, in_fu_nzcv : broadcast
//   in_fu_alu_ready, out_fu_alu_start, out_fu_alu_* : issue interface (registered)
//  Optional macro ALU_RS_STATS_EN adds out_stat_issued / out_stat_full_cycles
//  (wrapping 32-bit counters, cleared by reset only).
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = 8
) (
  input  logic                     in_clk,
  input  logic                     in_rst,
  input  logic                     in_flush,
  input  logic                     in_dispatch_valid,
  input  alu_op_t                  in_dispatch_op,
  input  logic [`GPR_SIZE-1:0]     in_dispatch_val_a,
  input  logic [`GPR_SIZE-1:0]     in_dispatch_val_b,
  input  logic                     in_dispatch_a_ready,
  input  logic                     in_dispatch_b_ready,
  input  logic [`ROB_IDX_SIZE-1:0] in_dispatch_a_rob_idx,
  input  logic [`ROB_IDX_SIZE-1:0] in_dispatch_b_rob_idx,
  input  logic [`ROB_IDX_SIZE-1:0] in_dispatch_dst_rob_index,
  input  logic                     in_dispatch_set_nzcv,
  input  nzcv_t                    in_dispatch_nzcv,
  input  logic                     in_dispatch_nzcv_ready,
  input  logic [`ROB_IDX_SIZE-1:0] in_dispatch_nzcv_rob_idx,
  output logic                     out_dispatch_ready,
  input  logic                     in_fu_done,
  input  logic [`ROB_IDX_SIZE-1:0] in_fu_dst_rob_index,
  input  logic [`GPR_SIZE-1:0]     in_fu_value,
  input  logic                     in_fu_set_nzcv,
  input  nzcv_t                    in_fu_nzcv,
  input  logic                     in_fu_alu_ready,
`ifdef ALU_RS_STATS_EN
  output logic [31:0]              out_stat_issued,
  output logic [31:0]              out_stat_full_cycles,
`endif
  output logic                     out_fu_alu_start,
  output alu_op_t                  out_fu_alu_op,
  output logic [`GPR_SIZE-1:0]     out_fu_alu_val_a,
  output logic [`GPR_SIZE-1:0]     out_fu_alu_val_b,
  output logic [`ROB_IDX_SIZE-1:0] out_fu_alu_dst_rob_index,
  output logic                     out_fu_alu_set_nzcv,
  output nzcv_t                    out_fu_alu_nzcv
);

  rs_entry_t [RS_SIZE-1:0] ent_q, ent_d;
  rs_entry_t               disp_e;
  rs_issue_t               iss;
  logic [RS_SIZE-1:0]      valid_vec, cand, grant, alloc_oh, alloc_en;
  logic                    dispatch_fire, issue_fire;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      valid_vec[i] = ent_q[i].valid;
      cand[i]      = ent_q[i].valid & ent_q[i].a_ready & ent_q[i].b_ready & ent_q[i].nzcv_ready;
    end
  end

  assign out_dispatch_ready = ~&valid_vec;

  // Lowest free slot: scan downward so the lowest index is written last.
  always_comb begin
    alloc_oh = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        alloc_oh    = '0;
        alloc_oh[i] = 1'b1;
      end
    end
  end

  assign dispatch_fire = in_dispatch_valid & out_dispatch_ready & ~in_flush;
  assign alloc_en      = alloc_oh & {RS_SIZE{dispatch_fire}};
  assign issue_fire    = in_fu_alu_ready & (|grant) & ~in_flush;

  rs_age_matrix #(.RS_SIZE(RS_SIZE)) u_age (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .alloc_oh (alloc_en),
    .valid    (valid_vec),
    .ready    (cand),
    .grant    (grant)
  );

  always_comb begin
    disp_e            = '0;
    disp_e.valid      = 1'b1;
    disp_e.op         = in_dispatch_op;
    disp_e.a_val      = in_dispatch_val_a;
    disp_e.a_ready    = in_dispatch_a_ready;
    disp_e.a_tag      = in_dispatch_a_rob_idx;
    disp_e.b_val      = in_dispatch_val_b;
    disp_e.b_ready    = in_dispatch_b_ready;
    disp_e.b_tag      = in_dispatch_b_rob_idx;
    disp_e.nzcv       = in_dispatch_nzcv;
    disp_e.nzcv_ready = in_dispatch_nzcv_ready;
    disp_e.nzcv_tag   = in_dispatch_nzcv_rob_idx;
    disp_e.set_nzcv   = in_dispatch_set_nzcv;
    disp_e.dst        = in_dispatch_dst_rob_index;
  end

  // Grant is one-hot, so a plain priority-free select is enough.
  always_comb begin
    iss = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (grant[i]) begin
        iss.op       = ent_q[i].op;
        iss.a_val    = ent_q[i].a_val;
        iss.b_val    = ent_q[i].b_val;
        iss.dst      = ent_q[i].dst;
        iss.set_nzcv = ent_q[i].set_nzcv;
        iss.nzcv     = ent_q[i].nzcv;
      end
    end
  end

  // Dispatch goes through the same wakeup path so a broadcast coinciding
  // with dispatch is not lost. Flush overrides everything.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = rs_wakeup(ent_q[i], in_fu_done, in_fu_dst_rob_index,
                           in_fu_value, in_fu_set_nzcv, in_fu_nzcv);
      if (issue_fire && grant[i])
        ent_d[i].valid = 1'b0;
      if (alloc_en[i])
        ent_d[i] = rs_wakeup(disp_e, in_fu_done, in_fu_dst_rob_index,
                             in_fu_value, in_fu_set_nzcv, in_fu_nzcv);
      if (in_flush)
        ent_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) ent_q <= '0;
    else        ent_q <= ent_d;
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_fu_alu_start         <= 1'b0;
      out_fu_alu_op            <= ALU_PLUS;
      out_fu_alu_val_a         <= '0;
      out_fu_alu_val_b         <= '0;
      out_fu_alu_dst_rob_index <= '0;
      out_fu_alu_set_nzcv      <= 1'b0;
      out_fu_alu_nzcv          <= '0;
    end else begin
      out_fu_alu_start <= issue_fire;
      if (issue_fire) begin
        out_fu_alu_op            <= iss.op;
        out_fu_alu_val_a         <= iss.a_val;
        out_fu_alu_val_b         <= iss.b_val;
        out_fu_alu_dst_rob_index <= iss.dst;
        out_fu_alu_set_nzcv      <= iss.set_nzcv;
        out_fu_alu_nzcv          <= iss.nzcv;
      end
    end
  end

`ifdef ALU_RS_STATS_EN
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_stat_issued      <= '0;
      out_stat_full_cycles <= '0;
    end else begin
      if (issue_fire)          out_stat_issued      <= out_stat_issued + 32'd1;
      if (!out_dispatch_ready) out_stat_full_cycles <= out_stat_full_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_rs.sv
// Randomized scoreboard bench for alu_rs. A queue-based reference model
// (entries kept in dispatch order) predicts each issue and pushes it into
// an expected-issue queue; an independent monitor pops on every start pulse.
// With ALU_RS_STATS_EN defined the statistics counters are checked too.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int RS = 8;

  logic                     in_clk, in_rst, in_flush;
  logic                     in_dispatch_valid;
  alu_op_t                  in_dispatch_op;
  logic [`GPR_SIZE-1:0]     in_dispatch_val_a, in_dispatch_val_b;
  logic                     in_dispatch_a_ready, in_dispatch_b_ready;
  logic [`ROB_IDX_SIZE-1:0] in_dispatch_a_rob_idx, in_dispatch_b_rob_idx;
  logic [`ROB_IDX_SIZE-1:0] in_dispatch_dst_rob_index;
  logic                     in_dispatch_set_nzcv;
  nzcv_t                    in_dispatch_nzcv;
  logic                     in_dispatch_nzcv_ready;
  logic [`ROB_IDX_SIZE-1:0] in_dispatch_nzcv_rob_idx;
  logic                     out_dispatch_ready;
  logic                     in_fu_done;
  logic [`ROB_IDX_SIZE-1:0] in_fu_dst_rob_index;
  logic [`GPR_SIZE-1:0]     in_fu_value;
  logic                     in_fu_set_nzcv;
  nzcv_t                    in_fu_nzcv;
  logic                     in_fu_alu_ready;
  logic                     out_fu_alu_start;
  alu_op_t                  out_fu_alu_op;
  logic [`GPR_SIZE-1:0]     out_fu_alu_val_a, out_fu_alu_val_b;
  logic [`ROB_IDX_SIZE-1:0] out_fu_alu_dst_rob_index;
  logic                     out_fu_alu_set_nzcv;
  nzcv_t                    out_fu_alu_nzcv;
`ifdef ALU_RS_STATS_EN
  logic [31:0]              out_stat_issued, out_stat_full_cycles;
`endif

  alu_rs #(.RS_SIZE(RS)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_flush(in_flush),
    .in_dispatch_valid(in_dispatch_valid), .in_dispatch_op(in_dispatch_op),
    .in_dispatch_val_a(in_dispatch_val_a), .in_dispatch_val_b(in_dispatch_val_b),
    .in_dispatch_a_ready(in_dispatch_a_ready), .in_dispatch_b_ready(in_dispatch_b_ready),
    .in_dispatch_a_rob_idx(in_dispatch_a_rob_idx), .in_dispatch_b_rob_idx(in_dispatch_b_rob_idx),
    .in_dispatch_dst_rob_index(in_dispatch_dst_rob_index),
    .in_dispatch_set_nzcv(in_dispatch_set_nzcv), .in_dispatch_nzcv(in_dispatch_nzcv),
    .in_dispatch_nzcv_ready(in_dispatch_nzcv_ready),
    .in_dispatch_nzcv_rob_idx(in_dispatch_nzcv_rob_idx),
    .out_dispatch_ready(out_dispatch_ready),
    .in_fu_done(in_fu_done), .in_fu_dst_rob_index(in_fu_dst_rob_index),
    .in_fu_value(in_fu_value), .in_fu_set_nzcv(in_fu_set_nzcv), .in_fu_nzcv(in_fu_nzcv),
    .in_fu_alu_ready(in_fu_alu_ready),
`ifdef ALU_RS_STATS_EN
    .out_stat_issued(out_stat_issued), .out_stat_full_cycles(out_stat_full_cycles),
`endif
    .out_fu_alu_start(out_fu_alu_start), .out_fu_alu_op(out_fu_alu_op),
    .out_fu_alu_val_a(out_fu_alu_val_a), .out_fu_alu_val_b(out_fu_alu_val_b),
    .out_fu_alu_dst_rob_index(out_fu_alu_dst_rob_index),
    .out_fu_alu_set_nzcv(out_fu_alu_set_nzcv), .out_fu_alu_nzcv(out_fu_alu_nzcv)
  );

  typedef struct {
    alu_op_t                  op;
    logic [`GPR_SIZE-1:0]     a, b;
    bit                       ar, br, nr;
    logic [`ROB_IDX_SIZE-1:0] at, bt, nt, dst;
    logic                     setn;
    nzcv_t                    n;
  } m_ent_t;

  typedef struct {
    alu_op_t                  op;
    logic [`GPR_SIZE-1:0]     a, b;
    logic [`ROB_IDX_SIZE-1:0] dst;
    logic                     setn;
    nzcv_t                    n;
    int                       cyc;
  } exp_t;

  m_ent_t mq[$];
  exp_t   expq[$];
  int     nvec = 0, nmis = 0, cyc = 0;
  int     m_issued = 0, m_full = 0;

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  initial forever @(posedge in_clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1);
  end

  // Apply the broadcast currently on the inputs to one model entry.
  function automatic m_ent_t m_wake(m_ent_t e);
    m_ent_t r = e;
    if (in_fu_done) begin
      if (!r.ar && r.at == in_fu_dst_rob_index) begin r.a = in_fu_value; r.ar = 1; end
      if (!r.br && r.bt == in_fu_dst_rob_index) begin r.b = in_fu_value; r.br = 1; end
      if (!r.nr && in_fu_set_nzcv && r.nt == in_fu_dst_rob_index) begin
        r.n = in_fu_nzcv; r.nr = 1;
      end
    end
    return r;
  endfunction

  // One clock edge of the reference: oldest-ready issue, then wakeup, then
  // append the dispatch if there was room before the edge.
  task automatic model_step();
    int     pick, sz;
    exp_t   x;
    m_ent_t e;
    sz = mq.size();
    if (sz == RS) m_full++;
    if (in_flush) begin
      mq.delete();
      return;
    end
    pick = -1;
    if (in_fu_alu_ready)
      for (int i = 0; i < mq.size(); i++)
        if (pick < 0 && mq[i].ar && mq[i].br && mq[i].nr) pick = i;
    if (pick >= 0) begin
      x.op = mq[pick].op; x.a = mq[pick].a; x.b = mq[pick].b;
      x.dst = mq[pick].dst; x.setn = mq[pick].setn; x.n = mq[pick].n;
      x.cyc = cyc + 1;
      expq.push_back(x);
      mq.delete(pick);
      m_issued++;
    end
    for (int i = 0; i < mq.size(); i++) mq[i] = m_wake(mq[i]);
    if (in_dispatch_valid && sz < RS) begin
      e.op = in_dispatch_op; e.a = in_dispatch_val_a; e.b = in_dispatch_val_b;
      e.ar = in_dispatch_a_ready; e.br = in_dispatch_b_ready; e.nr = in_dispatch_nzcv_ready;
      e.at = in_dispatch_a_rob_idx; e.bt = in_dispatch_b_rob_idx;
      e.nt = in_dispatch_nzcv_rob_idx; e.dst = in_dispatch_dst_rob_index;
      e.setn = in_dispatch_set_nzcv; e.n = in_dispatch_nzcv;
      mq.push_back(m_wake(e));
    end
  endtask

  task automatic idle();
    in_flush = 0; in_dispatch_valid = 0; in_dispatch_op = ALU_PLUS;
    in_dispatch_val_a = '0; in_dispatch_val_b = '0;
    in_dispatch_a_ready = 0; in_dispatch_b_ready = 0;
    in_dispatch_a_rob_idx = '0; in_dispatch_b_rob_idx = '0;
    in_dispatch_dst_rob_index = '0; in_dispatch_set_nzcv = 0;
    in_dispatch_nzcv = '0; in_dispatch_nzcv_ready = 0; in_dispatch_nzcv_rob_idx = '0;
    in_fu_done = 0; in_fu_dst_rob_index = '0; in_fu_value = '0;
    in_fu_set_nzcv = 0; in_fu_nzcv = '0; in_fu_alu_ready = 0;
  endtask

  task automatic set_disp(input m_ent_t e);
    in_dispatch_valid = 1; in_dispatch_op = e.op;
    in_dispatch_val_a = e.a; in_dispatch_val_b = e.b;
    in_dispatch_a_ready = e.ar; in_dispatch_b_ready = e.br; in_dispatch_nzcv_ready = e.nr;
    in_dispatch_a_rob_idx = e.at; in_dispatch_b_rob_idx = e.bt;
    in_dispatch_nzcv_rob_idx = e.nt; in_dispatch_dst_rob_index = e.dst;
    in_dispatch_set_nzcv = e.setn; in_dispatch_nzcv = e.n;
  endtask

  function automatic m_ent_t ready_ent(input logic [`GPR_SIZE-1:0] a, b,
                                       input logic [`ROB_IDX_SIZE-1:0] dst);
    m_ent_t e;
    e.op = ALU_PLUS; e.a = a; e.b = b; e.ar = 1; e.br = 1; e.nr = 1;
    e.at = '0; e.bt = '0; e.nt = '0; e.dst = dst; e.setn = 0; e.n = '0;
    return e;
  endfunction

  function automatic m_ent_t rand_ent();
    m_ent_t e;
    e.op = alu_op_t'($urandom_range(0, 7));
    e.a = {$urandom, $urandom}; e.b = {$urandom, $urandom};
    e.ar = ($urandom_range(0, 2) != 0); e.br = ($urandom_range(0, 2) != 0);
    e.nr = ($urandom_range(0, 3) != 0);
    e.at = `ROB_IDX_SIZE'($urandom_range(0, 7)); e.bt = `ROB_IDX_SIZE'($urandom_range(0, 7));
    e.nt = `ROB_IDX_SIZE'($urandom_range(0, 7)); e.dst = `ROB_IDX_SIZE'($urandom_range(0, 31));
    e.setn = 1'($urandom_range(0, 1)); e.n = nzcv_t'(4'($urandom_range(0, 15)));
    return e;
  endfunction

  // Called at a negedge with inputs applied: check dispatch-ready against
  // the model occupancy, advance the model, wait for the next negedge.
  task automatic step();
    nvec++;
    if (out_dispatch_ready !== (mq.size() < RS)) begin
      nmis++;
      $display("FAIL dispatch_ready @cyc %0d: got %0b want %0b", cyc, out_dispatch_ready, mq.size() < RS);
    end
    model_step();
    @(negedge in_clk);
  endtask

  task automatic chk_reset_outputs(input string nm);
    nvec++;
    if (out_fu_alu_start !== 1'b0 || out_fu_alu_val_a !== '0 || out_fu_alu_val_b !== '0 ||
        out_fu_alu_dst_rob_index !== '0 || out_fu_alu_op !== ALU_PLUS ||
        out_fu_alu_set_nzcv !== 1'b0 || out_fu_alu_nzcv !== '0) begin
      nmis++;
      $display("FAIL %s: got start=%0b a=%h b=%h dst=%0d, want all zero", nm,
               out_fu_alu_start, out_fu_alu_val_a, out_fu_alu_val_b, out_fu_alu_dst_rob_index);
    end
    nvec++;
    if (out_dispatch_ready !== 1'b1) begin
      nmis++;
      $display("FAIL %s_ready: got %0b want 1", nm, out_dispatch_ready);
    end
  endtask

  // Asynchronous reset between edges; called just after a negedge.
  task automatic async_reset();
    #2 in_rst = 1;
    mq.delete(); expq.delete(); m_issued = 0; m_full = 0;
    #1 chk_reset_outputs("async_reset");
    @(negedge in_clk);
    @(negedge in_clk);
    in_rst = 0;
  endtask

  // Monitor: every start pulse must match the next predicted issue.
  initial begin
    exp_t x;
    forever begin
      @(negedge in_clk);
      if (!in_rst && out_fu_alu_start === 1'b1) begin
        nvec++;
        if (expq.size() == 0) begin
          nmis++;
          $display("FAIL unexpected_start @cyc %0d: got start=1 dst=%0d, want no issue",
                   cyc, out_fu_alu_dst_rob_index);
        end else begin
          x = expq.pop_front();
          if (out_fu_alu_op !== x.op || out_fu_alu_val_a !== x.a || out_fu_alu_val_b !== x.b ||
              out_fu_alu_dst_rob_index !== x.dst || out_fu_alu_set_nzcv !== x.setn ||
              out_fu_alu_nzcv !== x.n) begin
            nmis++;
            $display("FAIL issue_fields @cyc %0d: got op=%0d a=%h b=%h dst=%0d sn=%0b f=%h, want op=%0d a=%h b=%h dst=%0d sn=%0b f=%h",
                     cyc, out_fu_alu_op, out_fu_alu_val_a, out_fu_alu_val_b,
                     out_fu_alu_dst_rob_index, out_fu_alu_set_nzcv, out_fu_alu_nzcv,
                     x.op, x.a, x.b, x.dst, x.setn, x.n);
          end
          nvec++;
          if (cyc != x.cyc) begin
            nmis++;
            $display("FAIL issue_timing: got cyc %0d want cyc %0d (dst %0d)", cyc, x.cyc, x.dst);
          end
        end
      end
    end
  end

  initial begin
    m_ent_t e;
    idle();
    in_rst = 1;
    #1 chk_reset_outputs("reset");
    @(negedge in_clk);
    @(negedge in_clk);
    in_rst = 0;

    // 1: all-ready PLUS 5+7 -> dst 3
    idle(); in_fu_alu_ready = 1;
    e = ready_ent(64'd5, 64'd7, 5'd3); set_disp(e); step();
    idle(); in_fu_alu_ready = 1; step(); step(); step();

    // 2: a waits on rob 9, woken with 40 two cycles later
    e = ready_ent(64'd0, 64'd1, 5'd10); e.ar = 0; e.at = 5'd9;
    idle(); in_fu_alu_ready = 1; set_disp(e); step();
    idle(); in_fu_alu_ready = 1; step();
    in_fu_done = 1; in_fu_dst_rob_index = 5'd9; in_fu_value = 64'd40; step();
    idle(); in_fu_alu_ready = 1; step(); step();

    // 3: fill with ALU stalled, 9th dispatch refused, then drain in order
    for (int i = 0; i < 9; i++) begin
      idle(); set_disp(ready_ent(64'(i * 3), 64'(i + 100), 5'(i))); step();
    end
    idle(); in_fu_alu_ready = 1;
    for (int i = 0; i < 10; i++) step();

    // 4: dispatch waiting on rob 4 while rob 4 broadcasts 0xFF
    e = ready_ent(64'd0, 64'd2, 5'd12); e.ar = 0; e.at = 5'd4;
    idle(); in_fu_alu_ready = 1; set_disp(e);
    in_fu_done = 1; in_fu_dst_rob_index = 5'd4; in_fu_value = 64'hFF; step();
    idle(); in_fu_alu_ready = 1; step(); step();

    // 5: flush with 3 entries and an issue pending, then reset mid-burst
    for (int i = 0; i < 3; i++) begin
      idle(); set_disp(ready_ent(64'(i), 64'(i), 5'(20 + i))); step();
    end
    idle(); in_fu_alu_ready = 1; in_flush = 1; step();
    idle(); in_fu_alu_ready = 1; step(); step(); step();
    for (int i = 0; i < 4; i++) begin
      idle(); in_fu_alu_ready = 1; set_disp(ready_ent(64'(i + 7), 64'(i + 9), 5'(i + 24))); step();
    end
    async_reset();

    // Random traffic with occasional flush and one mid-run reset
    for (int k = 0; k < 400; k++) begin
      idle();
      in_fu_alu_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) != 0) set_disp(rand_ent());
      if ($urandom_range(0, 2) == 0) begin
        in_fu_done = 1;
        in_fu_dst_rob_index = `ROB_IDX_SIZE'($urandom_range(0, 7));
        in_fu_value = {$urandom, $urandom};
        in_fu_set_nzcv = 1'($urandom_range(0, 1));
        in_fu_nzcv = nzcv_t'(4'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 49) == 0) in_flush = 1;
      step();
      if (k == 200) async_reset();
    end
    idle(); in_fu_alu_ready = 1;
    for (int i = 0; i < 4; i++) step();

`ifdef ALU_RS_STATS_EN
    nvec++;
    if (out_stat_issued !== 32'(m_issued) || out_stat_full_cycles !== 32'(m_full)) begin
      nmis++;
      $display("FAIL stats_random: got issued=%0d full=%0d want issued=%0d full=%0d",
               out_stat_issued, out_stat_full_cycles, m_issued, m_full);
    end
    // 6: exactly 3 issues and 2 full cycles after reset; flush keeps counts
    async_reset();
    for (int i = 0; i < 8; i++) begin
      idle(); set_disp(ready_ent(64'(i), 64'(i), 5'(i))); step();
    end
    idle(); step();
    idle(); in_fu_alu_ready = 1; step(); step(); step();
    idle(); step();
    idle(); in_flush = 1; step();
    idle(); step();
    nvec++;
    if (out_stat_issued !== 32'd3 || out_stat_full_cycles !== 32'd2) begin
      nmis++;
      $display("FAIL stats_directed: got issued=%0d full=%0d want issued=3 full=2",
               out_stat_issued, out_stat_full_cycles);
    end
`endif

    nvec++;
    if (expq.size() != 0) begin
      nmis++;
      $display("FAIL missing_issue: got 0 further starts, want %0d", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
